// File: rtl/fifo_sync_fwft.sv
// First-word-fall-through synchronous FIFO: block-RAM storage with synchronous
// read, a two-entry output/skid buffer for bubble-free streaming, level and almost flags.
module fifo_sync_fwft #(
  parameter int unsigned P_WIDTH     = 8,
  parameter int unsigned P_DEPTH     = 1024,
  parameter int unsigned P_AF_THRESH = P_DEPTH - 4,
  parameter int unsigned P_AE_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [$clog2(P_DEPTH):0]   level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned LW = AW + 1;

  if ((P_DEPTH < 4) || ((P_DEPTH & (P_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "fifo_sync_fwft: P_DEPTH must be a power of 2 and at least 4");
  end
  if ((P_AF_THRESH < 1) || (P_AF_THRESH > P_DEPTH)) begin : g_bad_af
    $fatal(1, "fifo_sync_fwft: P_AF_THRESH out of range 1..P_DEPTH");
  end
  if (P_AE_THRESH > P_DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_sync_fwft: P_AE_THRESH out of range 0..P_DEPTH-1");
  end

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_WIDTH-1:0] ram_rd_q;

  logic [LW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ram_dv_q, ram_dv_d;
  logic [P_WIDTH-1:0] out_data_q, out_data_d;
  logic               out_vld_q, out_vld_d;
  logic [P_WIDTH-1:0] skid_data_q, skid_data_d;
  logic               skid_vld_q, skid_vld_d;
  logic               wr_rdy_q, wr_rdy_d;
  logic               af_q, af_d;
  logic               ae_q, ae_d;

  logic               wr_acc;
  logic               rd_acc;
  logic               ram_empty;
  logic               ram_re;
  logic [1:0]         buf_after;

  assign wr_acc    = wr_vld & wr_rdy_q;
  assign rd_acc    = out_vld_q & rd_rdy;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);

  // Words held in the output/skid pair after this edge; a RAM read issued now
  // lands one cycle later, so only issue while that count leaves a free slot.
  assign buf_after = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_dv_q) - 2'(rd_acc);
  assign ram_re    = !ram_empty && (buf_after <= 2'd1);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ram_dv_d    = ram_re;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + LW'(1);
    if (ram_re) rd_ptr_d = rd_ptr_q + LW'(1);
    level_d = level_q + LW'(wr_acc) - LW'(rd_acc);

    // Output register is the head; the skid register only fills while the head stalls.
    if (!out_vld_q) begin
      if (ram_dv_q) begin
        out_data_d = ram_rd_q;
        out_vld_d  = 1'b1;
      end
    end else if (rd_acc) begin
      if (skid_vld_q) begin
        out_data_d  = skid_data_q;
        skid_vld_d  = ram_dv_q;
        skid_data_d = ram_dv_q ? ram_rd_q : skid_data_q;
      end else if (ram_dv_q) begin
        out_data_d = ram_rd_q;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_dv_q) begin
      skid_data_d = ram_rd_q;
      skid_vld_d  = 1'b1;
    end

    wr_rdy_d = (level_d != LW'(P_DEPTH));
    af_d     = (level_d >= LW'(P_AF_THRESH));
    ae_d     = (level_d <= LW'(P_AE_THRESH));

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      ram_dv_d    = 1'b0;
      out_data_d  = '0;
      out_vld_d   = 1'b0;
      skid_data_d = '0;
      skid_vld_d  = 1'b0;
      wr_rdy_d    = 1'b1;
      af_d        = 1'b0;
      ae_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ram_dv_q    <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      wr_rdy_q    <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ram_dv_q    <= ram_dv_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      wr_rdy_q    <= wr_rdy_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
    end
  end

  // Storage: no reset, synchronous read for block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush && !rst) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    if (ram_re) ram_rd_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  assign wr_rdy       = wr_rdy_q;
  assign rd_data      = out_data_q;
  assign rd_vld       = out_vld_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Self-checking bench for fifo_sync_fwft (depth 16, width 8) against a queue-based
// reference model: level, flags, ordering, fall-through latency, flush and reset.
module tb_fifo_sync_fwft;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 12;
  localparam int unsigned AE = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [W-1:0] wr_data;
  logic         wr_vld;
  logic         wr_rdy;
  logic [W-1:0] rd_data;
  logic         rd_vld;
  logic         rd_rdy;
  logic [4:0]   level;
  logic         almost_full;
  logic         almost_empty;

  fifo_sync_fwft #(
    .P_WIDTH    (W),
    .P_DEPTH    (D),
    .P_AF_THRESH(AF),
    .P_AE_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_vld      (wr_vld),
    .wr_rdy      (wr_rdy),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .rd_rdy      (rd_rdy),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int edge_no = 0;

  // Reference contents: data and the edge at which each word was accepted.
  logic [W-1:0] qd[$];
  int           qe[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(qd.size()));
    check("wr_rdy", 32'(wr_rdy), 32'(qd.size() != D));
    check("almost_full", 32'(almost_full), 32'(qd.size() >= AF));
    check("almost_empty", 32'(almost_empty), 32'(qd.size() <= AE));
    if (qd.size() == 0) check("rd_vld_when_empty", 32'(rd_vld), 0);
    else if (qe[0] <= edge_no - 2) check("rd_vld_head_due", 32'(rd_vld), 1);
    if (rd_vld && qd.size() > 0) check("rd_data_order", 32'(rd_data), 32'(qd[0]));
  endtask

  // One clock: drive inputs, predict handshakes, advance model, check outputs.
  task automatic step(input logic rs, input logic fl, input logic wv, input logic [W-1:0] wd,
                      input logic rr, output logic wacc, output logic racc);
    rst     = rs;
    flush   = fl;
    wr_vld  = wv;
    wr_data = wd;
    rd_rdy  = rr;
    wacc = wv && !fl && !rs && (qd.size() != D);
    racc = rr && rd_vld && !fl && !rs;
    @(posedge clk);
    #1;
    edge_no++;
    if (rs || fl) begin
      qd.delete();
      qe.delete();
    end else begin
      if (racc && qd.size() > 0) begin
        void'(qd.pop_front());
        void'(qe.pop_front());
      end
      if (wacc) begin
        qd.push_back(wd);
        qe.push_back(edge_no);
      end
    end
    check_state();
  endtask

  task automatic drain();
    logic wa, ra;
    for (int i = 0; i < 64 && qd.size() > 0; i++) step(0, 0, 0, '0, 1, wa, ra);
    check("drain_done", 32'(qd.size()), 0);
  endtask

  task automatic clear_test(input logic use_rst);
    logic wa, ra;
    int   waited;
    for (int i = 0; i < 10; i++) step(0, 0, 1, W'(8'h40 + i), 0, wa, ra);
    check("preload_level", 32'(level), 10);
    step(use_rst, !use_rst, 1, 8'h77, 1, wa, ra);
    check("clear_level", 32'(level), 0);
    check("clear_rd_vld", 32'(rd_vld), 0);
    check("clear_almost_empty", 32'(almost_empty), 1);
    check("clear_rd_data", 32'(rd_data), 0);
    step(0, 0, 1, 8'h3C, 0, wa, ra);
    waited = 0;
    while (!rd_vld && waited < 8) begin
      step(0, 0, 0, '0, 0, wa, ra);
      waited++;
    end
    check("clear_next_vld", 32'(rd_vld), 1);
    check("clear_next_data", 32'(rd_data), 32'h3C);
    step(0, 0, 0, '0, 1, wa, ra);
    check("clear_empty_after", 32'(level), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wa, ra;
    int   nxt, sent, got, seen, wp, rp;

    rst = 1'b1; flush = 1'b0; wr_vld = 1'b0; wr_data = '0; rd_rdy = 1'b0;
    step(1, 0, 0, '0, 0, wa, ra);
    step(1, 0, 0, '0, 0, wa, ra);
    check("reset_rd_data", 32'(rd_data), 0);
    check("reset_rd_vld", 32'(rd_vld), 0);
    check("reset_wr_rdy", 32'(wr_rdy), 1);

    // Fall-through latency of a single word into an empty FIFO.
    step(0, 0, 1, 8'hA5, 0, wa, ra);
    check("ft_level_e", 32'(level), 1);
    check("ft_vld_e", 32'(rd_vld), 0);
    step(0, 0, 0, '0, 0, wa, ra);
    check("ft_level_e1", 32'(level), 1);
    check("ft_vld_e1", 32'(rd_vld), 0);
    step(0, 0, 0, '0, 0, wa, ra);
    check("ft_vld_e2", 32'(rd_vld), 1);
    check("ft_data_e2", 32'(rd_data), 32'hA5);
    step(0, 0, 0, '0, 1, wa, ra);

    // Fill to capacity with the reader stalled.
    for (int i = 0; i < 16; i++) step(0, 0, 1, W'(i), 0, wa, ra);
    check("full_level", 32'(level), 16);
    check("full_wr_rdy", 32'(wr_rdy), 0);
    check("full_af", 32'(almost_full), 1);
    step(0, 0, 1, 8'hEE, 0, wa, ra);
    check("full_blocked_wacc", 32'(wa), 0);
    check("full_blocked_level", 32'(level), 16);

    // Read and write together from full, across pointer wrap.
    nxt = 16;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, W'(nxt), 1, wa, ra);
      if (wa) nxt++;
      check("full_stream_level", 32'(level >= 15 && level <= 16), 1);
    end
    drain();

    // 100-word stream with continuous reader: no bubbles once data arrives.
    sent = 0; got = 0; seen = 0;
    for (int c = 0; c < 300 && got < 100; c++) begin
      step(0, 0, sent < 100, W'(sent + 8'h80), 1, wa, ra);
      if (wa) sent++;
      if (ra) got++;
      if (seen != 0 && got < 100) check("stream_no_bubble", 32'(rd_vld), 1);
      if (rd_vld) seen = 1;
    end
    check("stream_count", 32'(got), 100);
    drain();

    // Randomized traffic with varying write/read pressure.
    wp = 2; rp = 2;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        wp = $urandom_range(1, 4);
        rp = $urandom_range(1, 4);
      end
      step(0, 0, ($urandom_range(0, 3) < wp), W'($urandom), ($urandom_range(0, 3) < rp), wa, ra);
    end
    drain();

    clear_test(1'b0);
    clear_test(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
